// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipeline register chain and its neighbours in the ALU datapath.
package pipe_reg_chain_pkg;

   localparam int ALU_NB_DATA = 8;

   // Width needed to count 0..2*n_stages held words.
   function automatic int occ_width(input int n_stages);
      return $clog2(2 * n_stages + 1);
   endfunction

endpackage

// File: rtl/skid_stage.sv
// One pipeline stage: a main register plus a skid register, so upstream ready comes
// straight from a flop and never depends on downstream ready within the same cycle.
module skid_stage
   import pipe_reg_chain_pkg::*;
#(
   parameter int NB_DATA = ALU_NB_DATA
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_flush,
   input  logic               s_valid,
   input  logic [NB_DATA-1:0] s_data,
   output logic               s_ready,
   output logic               m_valid,
   output logic [NB_DATA-1:0] m_data,
   input  logic               m_ready,
   output logic [1:0]         o_held
);

   logic               main_v;
   logic               skid_v;
   logic [NB_DATA-1:0] main_d;
   logic [NB_DATA-1:0] skid_d;
   logic               s_xfer;

   assign s_ready = ~skid_v;
   assign s_xfer  = s_valid & ~skid_v;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_d <= '0;
         skid_d <= '0;
      end else if (i_flush) begin
         // Data registers keep their contents; only the flags are dropped.
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else if (m_ready || !main_v) begin
         if (skid_v) begin
            main_d <= skid_d;
            main_v <= 1'b1;
            skid_v <= 1'b0;
         end else begin
            main_v <= s_xfer;
            if (s_xfer) begin
               main_d <= s_data;
            end
         end
      end else if (s_xfer) begin
         skid_d <= s_data;
         skid_v <= 1'b1;
      end
   end

   assign m_valid = main_v;
   assign m_data  = main_d;
   assign o_held  = 2'(main_v) + 2'(skid_v);

endmodule

// File: rtl/pipe_reg_chain.sv
// Pipeline register chain: N_STAGES skid stages in series, with synchronous flush and a
// live count of held words.
module pipe_reg_chain
   import pipe_reg_chain_pkg::*;
#(
   parameter int NB_DATA  = ALU_NB_DATA,
   parameter int N_STAGES = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_flush,
   input  logic                           i_valid,
   input  logic [NB_DATA-1:0]             i_data,
   output logic                           o_ready,
   output logic                           o_valid,
   output logic [NB_DATA-1:0]             o_data,
   input  logic                           i_ready,
   output logic [occ_width(N_STAGES)-1:0] o_occupancy
);

   localparam int OCC_W = occ_width(N_STAGES);

   logic [N_STAGES:0]  vld;
   logic [N_STAGES:0]  rdy;
   logic [NB_DATA-1:0] dat  [N_STAGES+1];
   logic [1:0]         held [N_STAGES];
   logic [OCC_W-1:0]   occ_sum;

   assign vld[0]        = i_valid;
   assign dat[0]        = i_data;
   assign o_ready       = rdy[0];
   assign o_valid       = vld[N_STAGES];
   assign o_data        = dat[N_STAGES];
   assign rdy[N_STAGES] = i_ready;

   // Stage k drains into stage k+1; index 0 is the upstream side.
   for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
      skid_stage #(
         .NB_DATA (NB_DATA)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_flush (i_flush),
         .s_valid (vld[g]),
         .s_data  (dat[g]),
         .s_ready (rdy[g]),
         .m_valid (vld[g+1]),
         .m_data  (dat[g+1]),
         .m_ready (rdy[g+1]),
         .o_held  (held[g])
      );
   end

   always_comb begin
      occ_sum = '0;
      for (int k = 0; k < N_STAGES; k++) begin
         occ_sum = occ_sum + OCC_W'(held[k]);
      end
   end

   assign o_occupancy = occ_sum;

endmodule
